// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizing helpers for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN,
        ISTALL,
        DSTALL,
        DRAIN,
        HALTED
    } pipeState_e;

    localparam int DEFAULT_CNT_W        = 16;
    localparam int DEFAULT_DRAIN_CYCLES = 3;

    // Drain counter must hold DRAIN_CYCLES; never let the width collapse to zero.
    function automatic int drainCntWidth(input int drainCycles);
        return (drainCycles < 1) ? 1 : $clog2(drainCycles + 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear on rst.
module sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stalls, bubbles and halt sequencing for a 5-stage pipe.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES,
    parameter int CNT_W        = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lduse_hazard,
    input  logic             branch_taken,
    input  logic             halt_dec,
    input  logic             imem_stall,
    input  logic             imem_done,
    input  logic             dmem_stall,
    input  logic             dmem_done,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int DRAIN_W = drainCntWidth(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

    pipeState_e         state;
    pipeState_e         resumeState;
    logic               pending;
    logic [DRAIN_W-1:0] drainCnt;
    logic [4:0]         enables;
    logic               resumeToRun;

    // An imem completion seen during (or on the last cycle of) a data stall means the fetch is already done.
    assign resumeToRun = (resumeState == ISTALL) && (pending || imem_done);

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = enables;

    always_comb begin
        enables    = 5'b00000;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (dmem_stall) begin
                        enables = 5'b00000;
                    end else if (branch_taken) begin
                        enables    = 5'b11111;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lduse_hazard) begin
                        enables    = 5'b00111;
                        idex_flush = 1'b1;
                    end else if (imem_stall) begin
                        enables    = 5'b01111;
                        ifid_flush = 1'b1;
                    end else begin
                        enables = 5'b11111;
                    end
                end
                ISTALL: begin
                    if (dmem_stall) begin
                        enables = 5'b00000;
                    end else if (branch_taken) begin
                        enables    = 5'b11111;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (imem_done) begin
                        enables = 5'b11111;
                    end else begin
                        enables    = 5'b01111;
                        ifid_flush = 1'b1;
                    end
                end
                DSTALL: begin
                    if (dmem_done) begin
                        enables    = 5'b11111;
                        ifid_flush = ((resumeState == ISTALL) && !resumeToRun) ||
                                     (resumeState == DRAIN);
                    end
                end
                DRAIN: begin
                    if (dmem_stall) begin
                        enables = 5'b00000;
                    end else if (branch_taken) begin
                        enables    = 5'b11111;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else begin
                        enables    = 5'b01111;
                        ifid_flush = 1'b1;
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    enables = 5'b00000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            resumeState <= RUN;
            pending     <= 1'b0;
            drainCnt    <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (dmem_stall) begin
                        resumeState <= RUN;
                        state       <= DSTALL;
                    end else if (branch_taken || lduse_hazard) begin
                        state <= RUN;
                    end else if (imem_stall) begin
                        state <= ISTALL;
                    end else if (halt_dec) begin
                        drainCnt <= DRAIN_LOAD;
                        state    <= (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
                    end
                end
                ISTALL: begin
                    if (dmem_stall) begin
                        resumeState <= ISTALL;
                        state       <= DSTALL;
                    end else if (!branch_taken && imem_done) begin
                        state <= RUN;
                    end
                end
                DSTALL: begin
                    if (dmem_done) begin
                        state   <= resumeToRun ? RUN : resumeState;
                        pending <= 1'b0;
                    end else if (imem_done && (resumeState == ISTALL)) begin
                        pending <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (dmem_stall) begin
                        resumeState <= DRAIN;
                        state       <= DSTALL;
                    end else if (branch_taken) begin
                        drainCnt <= '0;
                        state    <= RUN;
                    end else begin
                        drainCnt <= drainCnt - DRAIN_ONE;
                        if (drainCnt <= DRAIN_ONE) begin
                            state <= HALTED;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) stallCounter (
        .clk   (clk),
        .rst   (rst),
        .inc   (!pc_en && (state != HALTED)),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with a queue-based scoreboard checked by a separate monitor.
module tb_pipe_ctrl;

    localparam int CNT_W        = 4;
    localparam int DRAIN_CYCLES = 3;

    // Stimulus bits: {rst, lduse, branch, halt, imemStall, imemDone, dmemStall, dmemDone}
    localparam logic [7:0] I_NONE = 8'h00;
    localparam logic [7:0] I_RST  = 8'h80;
    localparam logic [7:0] I_LDU  = 8'h40;
    localparam logic [7:0] I_BR   = 8'h20;
    localparam logic [7:0] I_HALT = 8'h10;
    localparam logic [7:0] I_IS   = 8'h08;
    localparam logic [7:0] I_ID   = 8'h04;
    localparam logic [7:0] I_DS   = 8'h02;
    localparam logic [7:0] I_DD   = 8'h01;

    // Expected bits: {pc, ifid, idex, exmem, memwb, ifidFlush, idexFlush, halted}
    localparam logic [7:0] E_ZERO   = 8'b00000_00_0;
    localparam logic [7:0] E_RUN    = 8'b11111_00_0;
    localparam logic [7:0] E_LDU    = 8'b00111_01_0;
    localparam logic [7:0] E_BR     = 8'b11111_11_0;
    localparam logic [7:0] E_FS     = 8'b01111_10_0;
    localparam logic [7:0] E_DDFL   = 8'b11111_10_0;
    localparam logic [7:0] E_HALTED = 8'b00000_00_1;

    typedef struct {
        string            name;
        logic [7:0]       ctl;
        logic [CNT_W-1:0] cnt;
    } expect_t;

    logic clk = 1'b0;
    logic rst, lduse_hazard, branch_taken, halt_dec;
    logic imem_stall, imem_done, dmem_stall, dmem_done;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, halted;
    logic [CNT_W-1:0] stall_cnt;

    expect_t          expQ[$];
    int               total = 0;
    int               bad   = 0;
    logic [CNT_W-1:0] modelCnt;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lduse_hazard(lduse_hazard),
        .branch_taken(branch_taken),
        .halt_dec    (halt_dec),
        .imem_stall  (imem_stall),
        .imem_done   (imem_done),
        .dmem_stall  (dmem_stall),
        .dmem_done   (dmem_done),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .halted      (halted),
        .stall_cnt   (stall_cnt)
    );

    task automatic applyStimulus(input string name, input logic [7:0] stim, input logic [7:0] expCtl);
        expect_t e;
        @(posedge clk);
        #1;
        {rst, lduse_hazard, branch_taken, halt_dec,
         imem_stall, imem_done, dmem_stall, dmem_done} = stim;
        e.name = name;
        e.ctl  = expCtl;
        e.cnt  = modelCnt;
        expQ.push_back(e);
        // stall_cnt counts cycles with pc_en low outside HALTED, saturating
        if (stim[7]) begin
            modelCnt = '0;
        end else if (!expCtl[7] && !expCtl[0] && (modelCnt != '1)) begin
            modelCnt = modelCnt + 1'b1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] expCtl, input logic [7:0] gotCtl,
                               input logic [CNT_W-1:0] expCnt, input logic [CNT_W-1:0] gotCnt);
        total++;
        if (gotCtl !== expCtl) begin
            bad++;
            $display("[TB] FAIL %s ctl got=%b want=%b", name, gotCtl, expCtl);
        end
        total++;
        if (gotCnt !== expCnt) begin
            bad++;
            $display("[TB] FAIL %s stall_cnt got=%0d want=%0d", name, gotCnt, expCnt);
        end
    endtask

    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.name, e.ctl,
                            {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted},
                            e.cnt, stall_cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        {rst, lduse_hazard, branch_taken, halt_dec,
         imem_stall, imem_done, dmem_stall, dmem_done} = I_RST;
        modelCnt = '0;
        @(posedge clk);

        applyStimulus("reset", I_RST, E_ZERO);
        applyStimulus("idle", I_NONE, E_RUN);

        applyStimulus("lduse", I_LDU, E_LDU);
        applyStimulus("lduse_after", I_NONE, E_RUN);
        applyStimulus("br_over_lduse", I_BR | I_LDU, E_BR);
        applyStimulus("br_after", I_NONE, E_RUN);

        applyStimulus("dstall_enter", I_DS, E_ZERO);
        for (int i = 0; i < 3; i++) applyStimulus("dstall_wait", I_DS, E_ZERO);
        applyStimulus("dstall_done", I_DD, E_RUN);
        applyStimulus("dstall_back", I_NONE, E_RUN);
        applyStimulus("dstall_prio", I_DS | I_BR | I_LDU | I_IS, E_ZERO);
        applyStimulus("dstall_prio_done", I_DD, E_RUN);

        applyStimulus("reset", I_RST, E_ZERO);
        applyStimulus("istall_enter", I_IS, E_FS);
        applyStimulus("istall_hold", I_IS, E_FS);
        applyStimulus("istall_dstall", I_DS, E_ZERO);
        applyStimulus("istall_pend", I_ID, E_ZERO);
        applyStimulus("istall_dwait", I_NONE, E_ZERO);
        applyStimulus("istall_ddone_pend", I_DD, E_RUN);
        applyStimulus("istall_nofetch", I_NONE, E_RUN);

        applyStimulus("is2_enter", I_IS, E_FS);
        applyStimulus("is2_dstall", I_DS, E_ZERO);
        applyStimulus("is2_ddone", I_DD, E_DDFL);
        applyStimulus("is2_still", I_NONE, E_FS);
        applyStimulus("is2_idone", I_ID, E_RUN);
        applyStimulus("is2_run", I_NONE, E_RUN);

        applyStimulus("is3_enter", I_IS, E_FS);
        applyStimulus("is3_branch", I_BR, E_BR);
        applyStimulus("is3_still", I_NONE, E_FS);
        applyStimulus("is3_idone", I_ID, E_RUN);

        applyStimulus("reset", I_RST, E_ZERO);
        applyStimulus("halt", I_HALT, E_RUN);
        for (int i = 0; i < 3; i++) applyStimulus("drain", I_NONE, E_FS);
        applyStimulus("halted", I_NONE, E_HALTED);
        applyStimulus("halted_ignore", I_BR | I_DS | I_IS, E_HALTED);
        applyStimulus("halted_hold", I_NONE, E_HALTED);
        applyStimulus("halted_reset", I_RST, E_ZERO);
        applyStimulus("after_halt_reset", I_NONE, E_RUN);

        applyStimulus("halt_br", I_HALT, E_RUN);
        applyStimulus("drain1", I_NONE, E_FS);
        applyStimulus("drain_branch", I_BR, E_BR);
        for (int i = 0; i < 4; i++) applyStimulus("no_halt", I_NONE, E_RUN);

        applyStimulus("reset", I_RST, E_ZERO);
        applyStimulus("halt_ds", I_HALT, E_RUN);
        applyStimulus("drain_a", I_NONE, E_FS);
        applyStimulus("drain_dstall", I_DS, E_ZERO);
        applyStimulus("drain_ddone", I_DD, E_DDFL);
        applyStimulus("drain_b", I_NONE, E_FS);
        applyStimulus("drain_c", I_NONE, E_FS);
        applyStimulus("drain_halted", I_NONE, E_HALTED);

        applyStimulus("reset", I_RST, E_ZERO);
        applyStimulus("halt_rst", I_HALT, E_RUN);
        applyStimulus("drain_rst1", I_NONE, E_FS);
        applyStimulus("drain_rst", I_RST, E_ZERO);
        applyStimulus("drain_rst_run", I_NONE, E_RUN);
        applyStimulus("drain_rst_run2", I_NONE, E_RUN);
        applyStimulus("mid_dstall", I_DS, E_ZERO);
        applyStimulus("dstall_rst", I_RST, E_ZERO);
        applyStimulus("dstall_rst_run", I_NONE, E_RUN);

        applyStimulus("reset", I_RST, E_ZERO);
        for (int i = 0; i < 20; i++) applyStimulus("lduse_sat", I_LDU, E_LDU);
        applyStimulus("sat_hold", I_NONE, E_RUN);
        applyStimulus("sat_reset", I_RST, E_ZERO);
        applyStimulus("sat_cleared", I_NONE, E_RUN);

        repeat (3) @(posedge clk);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain left=%0d want=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, giving the number of cycles the back end runs after a halt before freezing.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the stall counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 lduse_hazard  in  1  load-use hazard from forwarding/hazard logic (EX-stage load feeds ID/EX consumer).
REQ-007 branch_taken  in  1  branch/jump resolved taken in EX this cycle.
REQ-008 halt_dec  in  1  halt instruction in decode.
REQ-009 imem_stall, imem_done  in  1 each  instruction-memory busy / completion handshake.
REQ-010 dmem_stall, dmem_done  in  1 each  data-memory busy / completion handshake.
REQ-011 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline-register write enables.
REQ-012 ifid_flush, idex_flush  out  1 each  load a NOP bubble into IF/ID or ID/EX.
REQ-013 halted  out  1  pipeline frozen after halt.
REQ-014 stall_cnt  out  CNT_W  count of front-end stall cycles.

Function
REQ-015 SHALL implement states RUN, ISTALL, DSTALL, DRAIN, HALTED; outputs combinational from state and inputs.
REQ-016 RUN priority SHALL be dmem_stall > branch_taken > lduse_hazard > imem_stall > halt_dec; with none asserted, all enables =1 and flushes =0.
REQ-017 dmem_stall in RUN, ISTALL or DRAIN SHALL drive all enables =0 and flushes =0, save the current state as resume state, and enter DSTALL.
REQ-018 DSTALL SHALL hold all enables at 0 until dmem_done; the dmem_done cycle SHALL assert all enables, apply the resume state's flush outputs, and return to the resume state.
REQ-019 imem_done arriving during DSTALL with resume=ISTALL SHALL be latched as pending; the return then goes to RUN, not ISTALL.
REQ-020 branch_taken in RUN SHALL assert pc_en=1, ifid_flush=1, idex_flush=1, and all other enables =1 (same cycle, zero latency).
REQ-021 lduse_hazard in RUN SHALL assert pc_en=0, ifid_en=0, idex_flush=1, idex_en=exmem_en=memwb_en=1, for exactly the cycles it is asserted.
REQ-022 imem_stall in RUN SHALL enter ISTALL; while in ISTALL, pc_en=0 and ifid_flush=1, with downstream enables =1.
REQ-023 imem_done in ISTALL SHALL assert pc_en=ifid_en=1, ifid_flush=0, and return to RUN.
REQ-024 branch_taken in ISTALL SHALL flush IF/ID and ID/EX and remain in ISTALL.
REQ-025 halt_dec in RUN SHALL enter DRAIN loading drain counter =DRAIN_CYCLES; in DRAIN, pc_en=0, ifid_flush=1, downstream enables =1.
REQ-026 In DRAIN the counter SHALL decrement each cycle not in DSTALL and SHALL enter HALTED when it reaches 0.
REQ-027 branch_taken in DRAIN SHALL cancel the halt (older branch squashes it): flush IF/ID and ID/EX, pc_en=1, return to RUN.
REQ-028 HALTED SHALL drive all enables =0 and halted=1, and SHALL persist until rst.
REQ-029 stall_cnt SHALL increment each cycle pc_en=0 and state!=HALTED, and SHALL saturate at all-ones (no wrap).

Reset
REQ-030 rst SHALL force state RUN, resume state RUN, pending=0, drain counter=0, and stall_cnt=0; rst has priority over all inputs, including mid-DSTALL and mid-DRAIN.
REQ-031 In the reset cycle, outputs SHALL be all enables =0, flushes =0, halted=0.

Structure
REQ-032 State encoding, DRAIN counter width ($clog2(DRAIN_CYCLES+1)) and the default CNT_W SHALL be defined in a shared package, pipe_ctrl_pkg.
REQ-033 The saturating counter SHALL be a sub-module, sat_counter, parameterised by width.

Verification
REQ-034 lduse_hazard=1 for 1 cycle in RUN -> pc_en=0, ifid_en=0, idex_flush=1 in that cycle; stall_cnt goes 0->1.
REQ-035 dmem_stall=1 in RUN, dmem_done after 4 cycles -> all enables =0 for 4 cycles, =1 on the done cycle, state back to RUN.
REQ-036 imem_stall in RUN, then dmem_stall, then imem_done during DSTALL, then dmem_done -> returns to RUN with no extra fetch stall.
REQ-037 halt_dec with DRAIN_CYCLES=3 -> 3 drain cycles with downstream enables =1, then halted=1 with all enables =0 until rst.
REQ-038 halt_dec, then branch_taken on the 2nd drain cycle -> ifid_flush=idex_flush=1, pc_en=1, halted never asserts.
REQ-039 CNT_W=4, 20 consecutive lduse cycles -> stall_cnt saturates at 15; rst -> 0.
